// File: rtl/rect_renderer.sv
// Rectangle rasteriser: latches a rectangle on start and streams its pixel
// coordinates in row-major order over a valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for start; operands latched when it arrives
// DRAW  | presenting one pixel per cycle, advancing on pix_ready
// DONE  | one-cycle done pulse, then back to IDLE
module rect_renderer #(
   parameter int X_W    = 9,
   parameter int Y_W    = 8,
   parameter int SIZE_W = 8
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              start,
   input  logic [X_W-1:0]    origin_x,
   input  logic [Y_W-1:0]    origin_y,
   input  logic [SIZE_W-1:0] width,
   input  logic [SIZE_W-1:0] height,
   input  logic              outline,
   output logic              busy,
   output logic              pix_valid,
   input  logic              pix_ready,
   output logic [X_W-1:0]    out_x,
   output logic [Y_W-1:0]    out_y,
   output logic              done
);

   typedef enum logic [1:0] {S_IDLE, S_DRAW, S_DONE} state_t;

   state_t            state;
   logic [X_W-1:0]    ox_q;
   logic [Y_W-1:0]    oy_q;
   logic [SIZE_W-1:0] wid_q;
   logic [SIZE_W-1:0] hgt_q;
   logic              outl_q;
   logic [SIZE_W-1:0] cx;
   logic [SIZE_W-1:0] cy;

   logic [SIZE_W-1:0] w_m1;
   logic [SIZE_W-1:0] h_m1;
   logic              at_row_end;
   logic              last_row;
   logic              last_pix;
   logic              interior;
   logic [SIZE_W-1:0] nx;
   logic [SIZE_W-1:0] ny;

   // w_m1/h_m1 are only meaningful in DRAW, where both sizes are nonzero.
   always_comb begin
      w_m1       = wid_q - SIZE_W'(1);
      h_m1       = hgt_q - SIZE_W'(1);
      at_row_end = (cx == w_m1);
      last_row   = (cy == h_m1);
      last_pix   = at_row_end && last_row;
      interior   = outl_q && (cy != '0) && !last_row;
      nx         = cx + SIZE_W'(1);
      ny         = cy;
      if (interior && (cx == '0) && !at_row_end) begin
         nx = w_m1;
      end else if (at_row_end) begin
         nx = '0;
         ny = cy + SIZE_W'(1);
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state     <= S_IDLE;
         busy      <= 1'b0;
         pix_valid <= 1'b0;
         done      <= 1'b0;
         out_x     <= '0;
         out_y     <= '0;
         cx        <= '0;
         cy        <= '0;
         ox_q      <= '0;
         oy_q      <= '0;
         wid_q     <= '0;
         hgt_q     <= '0;
         outl_q    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  ox_q   <= origin_x;
                  oy_q   <= origin_y;
                  wid_q  <= width;
                  hgt_q  <= height;
                  outl_q <= outline;
                  cx     <= '0;
                  cy     <= '0;
                  busy   <= 1'b1;
                  if ((width == '0) || (height == '0)) begin
                     state <= S_DONE;
                     done  <= 1'b1;
                  end else begin
                     state     <= S_DRAW;
                     pix_valid <= 1'b1;
                     out_x     <= origin_x;
                     out_y     <= origin_y;
                  end
               end
            end
            S_DRAW: begin
               if (pix_ready) begin
                  if (last_pix) begin
                     state     <= S_DONE;
                     pix_valid <= 1'b0;
                     done      <= 1'b1;
                  end else begin
                     cx    <= nx;
                     cy    <= ny;
                     out_x <= ox_q + X_W'(nx);
                     out_y <= oy_q + Y_W'(ny);
                  end
               end
            end
            S_DONE: begin
               state <= S_IDLE;
               done  <= 1'b0;
               busy  <= 1'b0;
            end
            default: begin
               state     <= S_IDLE;
               busy      <= 1'b0;
               pix_valid <= 1'b0;
               done      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rect_renderer.sv
// Self-checking bench for rect_renderer: expected pixels are queued from a
// reference model and popped as the DUT hands each pixel over.
module tb_rect_renderer;

   logic       clock = 1'b0;
   logic       resetn;
   logic       start;
   logic [8:0] origin_x;
   logic [7:0] origin_y;
   logic [7:0] width;
   logic [7:0] height;
   logic       outline;
   logic       busy;
   logic       pix_valid;
   logic       pix_ready;
   logic [8:0] out_x;
   logic [7:0] out_y;
   logic       done;

   int total = 0;
   int bad   = 0;
   logic [16:0] sb[$];

   rect_renderer #(.X_W(9), .Y_W(8), .SIZE_W(8)) dut (
      .clock(clock), .resetn(resetn), .start(start),
      .origin_x(origin_x), .origin_y(origin_y), .width(width), .height(height),
      .outline(outline), .busy(busy), .pix_valid(pix_valid), .pix_ready(pix_ready),
      .out_x(out_x), .out_y(out_y), .done(done)
   );

   always #5 clock = ~clock;

   // Reference order: scan every position row-major, keep border cells in outline mode.
   task automatic push_model(input int ox, input int oy, input int w, input int h, input bit o);
      logic [8:0] xv;
      logic [7:0] yv;
      for (int y = 0; y < h; y++)
         for (int x = 0; x < w; x++)
            if (!o || y == 0 || y == h - 1 || x == 0 || x == w - 1) begin
               xv = 9'(ox + x);
               yv = 8'(oy + y);
               sb.push_back({xv, yv});
            end
   endtask

   task automatic do_start(input int ox, input int oy, input int w, input int h, input bit o);
      @(negedge clock);
      origin_x = 9'(ox); origin_y = 8'(oy); width = 8'(w); height = 8'(h); outline = o;
      start = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
   endtask

   task automatic test_reset;
      resetn = 1'b0; start = 1'b0; pix_ready = 1'b1;
      origin_x = '0; origin_y = '0; width = '0; height = '0; outline = 1'b0;
      sb.delete();
      repeat (3) @(negedge clock);
      total++; if (busy !== 1'b0)      begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
      total++; if (pix_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", pix_valid); end
      total++; if (done !== 1'b0)      begin bad++; $display("FAIL reset_done got=%b want=0", done); end
      total++; if ({out_x, out_y} !== 17'd0) begin bad++; $display("FAIL reset_xy got=(%0d,%0d) want=(0,0)", out_x, out_y); end
      resetn = 1'b1;
      @(negedge clock);
   endtask

   // Streams a queued rectangle with pix_ready high and checks exact cycle timing.
   task automatic test_stream(input string name, input int ox, input int oy, input int w,
                              input int h, input bit o, input bit glitch);
      int n;
      logic [16:0] exp;
      n = sb.size();
      pix_ready = 1'b1;
      do_start(ox, oy, w, h, o);
      for (int k = 1; k <= n; k++) begin
         @(negedge clock);
         if (glitch && k == 2) begin
            start = 1'b1; origin_x = 9'd200; origin_y = 8'd99; width = 8'd9; height = 8'd9;
         end
         if (glitch && k == 3) start = 1'b0;
         total++;
         if (pix_valid !== 1'b1 || done !== 1'b0) begin
            bad++; $display("FAIL %s_valid_c%0d got v=%b d=%b want v=1 d=0", name, k, pix_valid, done);
         end else begin
            exp = sb.pop_front();
            if ({out_x, out_y} !== exp) begin
               bad++;
               $display("FAIL %s_pix%0d got=(%0d,%0d) want=(%0d,%0d)", name, k, out_x, out_y, exp[16:8], exp[7:0]);
            end
         end
      end
      start = 1'b0;
      @(negedge clock);
      total++;
      if (done !== 1'b1 || pix_valid !== 1'b0 || busy !== 1'b1) begin
         bad++; $display("FAIL %s_done got d=%b v=%b b=%b want d=1 v=0 b=1", name, done, pix_valid, busy);
      end
      @(negedge clock);
      total++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         bad++; $display("FAIL %s_idle got d=%b b=%b want d=0 b=0", name, done, busy);
      end
      sb.delete();
   endtask

   task automatic test_fill;
      push_model(10, 20, 3, 2, 1'b0);
      test_stream("fill3x2", 10, 20, 3, 2, 1'b0, 1'b0);
   endtask

   task automatic test_outline;
      logic [8:0] xs [10] = '{0, 1, 2, 3, 0, 3, 0, 1, 2, 3};
      logic [7:0] ys [10] = '{0, 0, 0, 0, 1, 1, 2, 2, 2, 2};
      for (int i = 0; i < 10; i++) sb.push_back({xs[i], ys[i]});
      test_stream("outline4x3", 0, 0, 4, 3, 1'b1, 1'b0);
      push_model(7, 9, 1, 3, 1'b1);
      test_stream("outline1x3", 7, 9, 1, 3, 1'b1, 1'b0);
      push_model(30, 40, 5, 4, 1'b1);
      test_stream("outline5x4", 30, 40, 5, 4, 1'b1, 1'b0);
   endtask

   task automatic test_backpressure;
      bit pat [7] = '{1, 0, 0, 1, 1, 0, 1};
      logic [16:0] prev;
      logic [16:0] exp;
      push_model(100, 50, 2, 2, 1'b0);
      pix_ready = 1'b1;
      do_start(100, 50, 2, 2, 1'b0);
      prev = '0;
      for (int i = 0; i < 7; i++) begin
         @(negedge clock);
         total++;
         if (pix_valid !== 1'b1 || done !== 1'b0) begin
            bad++; $display("FAIL bp_valid_c%0d got v=%b d=%b want v=1 d=0", i, pix_valid, done);
         end
         if (i > 0 && !pat[i-1]) begin
            total++;
            if ({out_x, out_y} !== prev) begin
               bad++; $display("FAIL bp_hold_c%0d got=(%0d,%0d) want=(%0d,%0d)", i, out_x, out_y, prev[16:8], prev[7:0]);
            end
         end
         prev = {out_x, out_y};
         pix_ready = pat[i];
         if (pat[i]) begin
            exp = sb.pop_front();
            total++;
            if ({out_x, out_y} !== exp) begin
               bad++; $display("FAIL bp_pix_c%0d got=(%0d,%0d) want=(%0d,%0d)", i, out_x, out_y, exp[16:8], exp[7:0]);
            end
         end
      end
      pix_ready = 1'b1;
      @(negedge clock);
      total++;
      if (done !== 1'b1 || pix_valid !== 1'b0) begin
         bad++; $display("FAIL bp_done got d=%b v=%b want d=1 v=0", done, pix_valid);
      end
      @(negedge clock);
      total++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         bad++; $display("FAIL bp_idle got b=%b d=%b want b=0 d=0", busy, done);
      end
      sb.delete();
   endtask

   task automatic test_zero_size;
      int ws [2] = '{0, 3};
      int hs [2] = '{5, 0};
      for (int i = 0; i < 2; i++) begin
         do_start(4, 4, ws[i], hs[i], 1'b0);
         @(negedge clock);
         total++;
         if (done !== 1'b1 || pix_valid !== 1'b0 || busy !== 1'b1) begin
            bad++; $display("FAIL zero%0d_done got d=%b v=%b b=%b want d=1 v=0 b=1", i, done, pix_valid, busy);
         end
         @(negedge clock);
         total++;
         if (done !== 1'b0 || pix_valid !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL zero%0d_idle got d=%b v=%b b=%b want 0 0 0", i, done, pix_valid, busy);
         end
      end
   endtask

   task automatic test_reset_mid_draw;
      pix_ready = 1'b1;
      do_start(60, 70, 5, 5, 1'b0);
      repeat (3) @(negedge clock);
      resetn = 1'b0;
      #1;
      total++;
      if ({busy, pix_valid, done} !== 3'b000 || {out_x, out_y} !== 17'd0) begin
         bad++;
         $display("FAIL rst_mid got b=%b v=%b d=%b xy=(%0d,%0d) want all 0", busy, pix_valid, done, out_x, out_y);
      end
      @(negedge clock);
      resetn = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         total++;
         if (done !== 1'b0 || busy !== 1'b0 || pix_valid !== 1'b0) begin
            bad++; $display("FAIL rst_after_c%0d got d=%b b=%b v=%b want 0 0 0", i, done, busy, pix_valid);
         end
      end
   endtask

   task automatic test_wrap;
      push_model(510, 3, 4, 1, 1'b0);
      test_stream("wrap", 510, 3, 4, 1, 1'b0, 1'b0);
   endtask

   task automatic test_start_ignore;
      push_model(1, 1, 3, 2, 1'b0);
      test_stream("startign", 1, 1, 3, 2, 1'b0, 1'b1);
   endtask

   task automatic test_back_to_back;
      push_model(250, 254, 2, 3, 1'b0);
      test_stream("b2b_a", 250, 254, 2, 3, 1'b0, 1'b0);
      push_model(5, 6, 3, 3, 1'b1);
      test_stream("b2b_b", 5, 6, 3, 3, 1'b1, 1'b0);
   endtask

   initial begin
      test_reset;
      test_fill;
      test_outline;
      test_backpressure;
      test_zero_size;
      test_reset_mid_draw;
      test_wrap;
      test_start_ignore;
      test_back_to_back;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running want=finished");
      $fatal(1);
   end

endmodule
